// File: rtl/pb_pkg.sv
// Shared types and default timing constants for the mode push-button conditioner.
package pb_pkg;

  typedef enum logic [1:0] {
    UP   = 2'd0,
    DOWN = 2'd1,
    LONG = 2'd2
  } pb_state_t;

  // 50 MHz system clock: 20 ms debounce, 1 s long-hold
  localparam int unsigned DEB_CYC_DEF  = 1_000_000;
  localparam int unsigned LONG_CYC_DEF = 50_000_000;
  localparam int unsigned DEB_W_DEF    = 20;
  localparam int unsigned LONG_W_DEF   = 26;

  // Reduced set for simulation
  localparam int unsigned DEB_CYC_SIM  = 4;
  localparam int unsigned LONG_CYC_SIM = 16;
  localparam int unsigned DEB_W_SIM    = 3;
  localparam int unsigned LONG_W_SIM   = 5;

endpackage

// File: rtl/pb_sync.sv
// Two-flop synchronizer for an asynchronous input pin; reset level is a parameter.
module pb_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pb_debounce.sv
// Mode push-button conditioner: synchronize, debounce, and classify presses into
// single-cycle pressed / released / held pulses.
module pb_debounce
  import pb_pkg::*;
#(
  parameter int unsigned DEB_CYC  = DEB_CYC_DEF,
  parameter int unsigned LONG_CYC = LONG_CYC_DEF,
  parameter int unsigned DEB_W    = DEB_W_DEF,
  parameter int unsigned LONG_W   = LONG_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic PB,
  output logic PB_stable,
  output logic pressed,
  output logic released,
  output logic held
);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);

  logic              PB_s;
  logic [DEB_W-1:0]  deb_cnt;
  logic [LONG_W-1:0] hold_cnt;
  pb_state_t         state;

  pb_sync #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (PB),
    .q     (PB_s)
  );

  // Accept a new level only after DEB_CYC consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PB_stable <= 1'b1;
      deb_cnt   <= '0;
    end else if (PB_s == PB_stable) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      PB_stable <= PB_s;
      deb_cnt   <= '0;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  // Press classifier; release is checked before the hold count so the two never coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UP;
      hold_cnt <= '0;
      pressed  <= 1'b0;
      released <= 1'b0;
      held     <= 1'b0;
    end else begin
      pressed  <= 1'b0;
      released <= 1'b0;
      held     <= 1'b0;
      case (state)
        UP: begin
          if (!PB_stable) begin
            state    <= DOWN;
            pressed  <= 1'b1;
            hold_cnt <= '0;
          end
        end
        DOWN: begin
          if (PB_stable) begin
            state    <= UP;
            released <= 1'b1;
          end else if (hold_cnt == LONG_LAST) begin
            state <= LONG;
            held  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + LONG_W'(1);
          end
        end
        LONG: begin
          if (PB_stable) state <= UP;
        end
        default: state <= UP;
      endcase
    end
  end

endmodule

// File: tb/tb_pb_debounce.sv
// Scoreboard bench for pb_debounce: a window-based reference model predicts
// timestamped events; a negedge monitor matches what the DUT emits.
module tb_pb_debounce;
  import pb_pkg::*;

  localparam int DEB = int'(DEB_CYC_SIM);
  localparam int LNG = int'(LONG_CYC_SIM);

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_HELD  = 2;
  localparam int K_LO    = 3;
  localparam int K_HI    = 4;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic PB = 1'b1;
  logic PB_stable, pressed, released, held;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  expq[$];

  // Reference model state: pin delay line, sample window, press bookkeeping
  bit   m_stable;
  bit   p1, p2;
  bit   win[$];
  bit   press_act, held_done;
  int   fall_e;
  logic last_st = 1'b1;

  pb_debounce #(
    .DEB_CYC  (DEB_CYC_SIM),
    .LONG_CYC (LONG_CYC_SIM),
    .DEB_W    (DEB_W_SIM),
    .LONG_W   (LONG_W_SIM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .PB        (PB),
    .PB_stable (PB_stable),
    .pressed   (pressed),
    .released  (released),
    .held      (held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int k, int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    expq.push_back(e);
  endfunction

  function automatic void model_reset();
    m_stable  = 1'b1;
    p1        = 1'b1;
    p2        = 1'b1;
    press_act = 1'b0;
    held_done = 1'b0;
    win.delete();
    expq.delete();
  endfunction

  // Level changes once the last DEB synchronized samples all disagree with it;
  // held fires LNG cycles after pressed unless the level rose first.
  function automatic void model_step(bit p, int e);
    bit w;
    bit all_diff;
    w  = p2;
    p2 = p1;
    p1 = p;
    if (press_act && !held_done && e == fall_e + 1 + LNG) begin
      push(K_HELD, e);
      held_done = 1'b1;
    end
    win.push_back(w);
    if (win.size() > DEB) void'(win.pop_front());
    all_diff = (win.size() == DEB);
    foreach (win[i]) if (win[i] == m_stable) all_diff = 1'b0;
    if (all_diff) begin
      m_stable = ~m_stable;
      if (!m_stable) begin
        push(K_LO, e);
        push(K_PRESS, e + 1);
        press_act = 1'b1;
        held_done = 1'b0;
        fall_e    = e;
      end else begin
        push(K_HI, e);
        if (press_act && !held_done) push(K_REL, e + 1);
        press_act = 1'b0;
      end
    end
  endfunction

  task automatic drive(bit p);
    @(posedge clk);
    #1;
    PB = p;
    model_step(p, cyc + 1);
  endtask

  task automatic hold(bit p, int n);
    repeat (n) drive(p);
  endtask

  task automatic release_reset(bit p);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    PB    = p;
    model_reset();
    model_step(p, cyc + 1);
  endtask

  task automatic check_reset_vals(string tag);
    checks++;
    if (PB_stable !== 1'b1 || pressed !== 1'b0 || released !== 1'b0 || held !== 1'b0) begin
      errors++;
      $display("FAIL %s: got stable=%b pressed=%b released=%b held=%b, expected 1 0 0 0",
               tag, PB_stable, pressed, released, held);
    end
  endtask

  task automatic expect_ev(int k);
    ev_t e;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected nothing", k, cyc);
    end else begin
      e = expq.pop_front();
      if (e.kind != k || e.cyc != cyc) begin
        errors++;
        $display("FAIL event_match: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                 k, cyc, e.kind, e.cyc);
      end
    end
  endtask

  // Monitor: pulses first, then level change, then anything overdue
  always @(negedge clk) begin
    if (rst_n) begin
      if (pressed || released || held) begin
        checks++;
        if (int'(pressed) + int'(released) + int'(held) > 1) begin
          errors++;
          $display("FAIL exclusive: got pressed=%b released=%b held=%b at cycle %0d, expected one",
                   pressed, released, held, cyc);
        end
      end
      if (pressed)  expect_ev(K_PRESS);
      if (released) expect_ev(K_REL);
      if (held)     expect_ev(K_HELD);
      if (PB_stable !== last_st) begin
        expect_ev(PB_stable === 1'b1 ? K_HI : K_LO);
        last_st = PB_stable;
      end
      while (expq.size() > 0 && expq[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_event: got nothing by cycle %0d, expected kind %0d at cycle %0d",
                 cyc, expq[0].kind, expq[0].cyc);
        void'(expq.pop_front());
      end
    end else begin
      last_st = 1'b1;
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset_state");
    release_reset(1'b1);
    hold(1'b1, 10);

    // Clean press and release
    hold(1'b0, 10);
    hold(1'b1, 12);

    // Bounce, then settle low
    repeat (5) begin
      hold(1'b0, 2);
      hold(1'b1, 2);
    end
    hold(1'b0, 12);
    hold(1'b1, 12);

    // Long hold
    hold(1'b0, 40);
    hold(1'b1, 12);

    // Debounce threshold boundary
    hold(1'b0, DEB - 1);
    hold(1'b1, 10);
    hold(1'b0, DEB);
    hold(1'b1, 12);

    // Reset while pressed, button still down afterwards
    hold(1'b0, 15);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_vals("async_reset_mid_press");
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("held_in_reset");
    release_reset(1'b0);
    hold(1'b0, 30);
    hold(1'b1, 12);

    // Back-to-back short presses
    repeat (4) begin
      hold(1'b0, 6);
      hold(1'b1, 6);
    end
    hold(1'b1, 6);

    // Random levels and durations, including sub-threshold glitches
    repeat (60) begin
      hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 24)));
    end
    hold(1'b1, 14);
    @(negedge clk);
    #1;

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending events, expected 0", expq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
